led_mode_controller: RTL and testbench
======================================

// Module: led_mode_controller
//
// PURPOSE
// Turns two raw push-buttons into a mode sequencer that drives the board's two LEDs.
// Sits between the top-level buttons/leds pins and replaces direct button->LED wiring.
// Each button is synchronised, debounced and edge-detected.
// A 4-state mode FSM then selects the LED pattern.
// A prescaler supplies the blink timing.
//
// PARAMETERS
// DEBOUNCE_CYCLES  4  consecutive cycles a synced input must differ from the stable value before it is accepted (>=1)
// BLINK_PERIOD     8  cycles per blink half-period, i.e. the phase toggles every BLINK_PERIOD cycles (>=2)
//
// PORTS
// clk      input   1  system clock; all logic on posedge
// rst      input   1  synchronous, active-high reset
// buttons  input   2  raw asynchronous buttons, active-high:
//                     [0] = advance mode, [1] = return to OFF
// leds     output  2  registered LED drive, active-high
// mode     output  2  current FSM state (debug/observability)
//
// BEHAVIOUR
// - Reset: at any posedge with rst=1, all state clears:
//   - sync flops, debounce counters, stable values, prescaler and phase go to 0
//   - mode -> OFF (2'd0), leds -> 2'b00, visible after that edge
//   - Reset mid-blink or mid-debounce discards all progress.
// - Synchroniser: 2 flops per button (sync1, sync2).
// - Debounce, per button:
//   - cnt clears whenever sync2 == stable.
//   - Otherwise cnt increments each edge.
//   - On the edge where cnt would reach DEBOUNCE_CYCLES: stable <= sync2 and cnt <= 0.
//   - A pulse shorter than DEBOUNCE_CYCLES consecutive synced cycles is ignored entirely.
// - Edge detect:
//   - stable_d is stable delayed one cycle.
//   - press = stable & ~stable_d is a 1-cycle pulse on 0->1 only.
//   - Holding a button yields exactly one press; release yields none.
// - A button already held when rst deasserts is treated as a fresh press once debounced.
// - Mode FSM, mode values OFF=0, ON=1, BLINK=2, ALT=3:
//   - press[1] -> OFF, from any state.
//   - else press[0] -> next state: OFF->ON->BLINK->ALT->OFF (wraps).
//   - Simultaneous press[0] & press[1]: press[1] wins, so the result is OFF.
//   - Every mode change (including a press[1] while already OFF) clears the prescaler and phase on the same edge.
// - Prescaler:
//   - Counts 0..BLINK_PERIOD-1 in every mode.
//   - On wrap, phase toggles.
// - LED pattern, registered one cycle after mode/phase:
//   - OFF: 00
//   - ON: 11
//   - BLINK: {~phase,~phase}, i.e. it starts lit
//   - ALT: phase ? 10 : 01, i.e. it starts at 01
// - Latency, with edge 0 = first posedge sampling buttons[i]=1 held steady:
//   - stable=1 after edge 1+DEBOUNCE_CYCLES
//   - mode updates at edge 2+DEBOUNCE_CYCLES
//   - leds update at edge 3+DEBOUNCE_CYCLES (defaults: edges 5/6/7)
// - Widths: counters sized $clog2(PARAM+1); no overflow is possible.
//
// TESTING
// 1. Reset: rst=1 for 2 edges with buttons=00 -> leds=00, mode=0; these hold for 25 edges after deassert.
// 2. Single press: buttons[0]=1 held 10 cycles -> mode=1 at edge 6, leds=11 at edge 7; holding longer gives no further advance.
// 3. Glitch reject: buttons[0] high for 3 cycles, then low -> mode and leds unchanged (defaults).
// 4. Blink/alt timing:
//    - Advance to BLINK -> leds 11 for 8 cycles, then 00 for 8, repeating.
//    - Advance to ALT -> 01/10 alternating every 8 cycles.
//    - Fourth press -> wraps to OFF, leds=00.
// 5. Priority/reset:
//    - In ALT, raise buttons=11 together -> mode=0 (OFF).
//    - In BLINK, assert rst for 1 edge -> leds=00, mode=0 immediately after that edge.

Source files
------------

// File: rtl/led_mode_controller.sv
// led_mode_controller: two synchronised, debounced buttons step a
// four-state LED mode machine; a prescaler supplies the blink phase.
module led_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_PERIOD    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] buttons,
    output logic [1:0] leds,
    output logic [1:0] mode
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(BLINK_PERIOD + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(BLINK_PERIOD - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        ALT   = 2'd3
    } mode_t;

    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_stable;
    logic [1:0]    r_stable_d;
    logic [DW-1:0] r_cnt [2];
    logic [PW-1:0] r_presc;
    logic          r_phase;
    logic [1:0]    r_leds;
    mode_t         r_mode;
    mode_t         w_mode_nxt;
    logic          w_mode_chg;
    logic [1:0]    w_press;
    logic [1:0]    w_led_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it differs for DEBOUNCE_CYCLES edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '{default: '0};
            r_stable <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_stable_d <= 2'b00;
        else     r_stable_d <= r_stable;
    end

    assign w_press = r_stable & ~r_stable_d;

    always_ff @(posedge clk) begin
        if (rst) r_mode <= OFF;
        else     r_mode <= w_mode_nxt;
    end

    // Return-to-OFF outranks advance
    always_comb begin
        w_mode_nxt = r_mode;
        w_mode_chg = 1'b0;
        if (w_press[1]) begin
            w_mode_nxt = OFF;
            w_mode_chg = 1'b1;
        end else if (w_press[0]) begin
            w_mode_chg = 1'b1;
            case (r_mode)
                OFF:   w_mode_nxt = ON;
                ON:    w_mode_nxt = BLINK;
                BLINK: w_mode_nxt = ALT;
                ALT:   w_mode_nxt = OFF;
                default: w_mode_nxt = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_mode_chg) begin
            r_presc <= '0;
            r_phase <= 1'b0;
        end else if (r_presc == PS_LAST) begin
            r_presc <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_comb begin
        w_led_nxt = 2'b00;
        case (r_mode)
            OFF:   w_led_nxt = 2'b00;
            ON:    w_led_nxt = 2'b11;
            BLINK: w_led_nxt = {2{~r_phase}};
            ALT:   w_led_nxt = r_phase ? 2'b10 : 2'b01;
            default: w_led_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_leds <= 2'b00;
        else     r_leds <= w_led_nxt;
    end

    assign leds = r_leds;
    assign mode = r_mode;

endmodule

// File: tb/tb_led_mode_controller.sv
// tb_led_mode_controller: directed button sequences; expected LED/mode
// values are queued per clock edge and checked by an independent monitor.
module tb_led_mode_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] buttons;
    logic [1:0] leds;
    logic [1:0] mode;

    led_mode_controller dut (
        .clk     (clk),
        .rst     (rst),
        .buttons (buttons),
        .leds    (leds),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] leds;
        bit         chk_leds;
        logic [1:0] mode;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void exp_at(input int c, input logic [1:0] l,
                                   input bit cl, input logic [1:0] m,
                                   input string nm);
        exp_t e;
        e.cyc      = c;
        e.leds     = l;
        e.chk_leds = cl;
        e.mode     = m;
        e.nm       = nm;
        sb.push_back(e);
    endfunction

    task automatic press(input logic [1:0] b, input int hold, input int gap);
        buttons = b;
        repeat (hold) @(negedge clk);
        buttons = 2'b00;
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: compare every queued expectation due at this edge
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= edge_n) begin
                n_chk++;
                if (sb[i].cyc < edge_n) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: check missed at edge %0d",
                             sb[i].nm, sb[i].cyc, edge_n);
                end else if (mode !== sb[i].mode ||
                             (sb[i].chk_leds && leds !== sb[i].leds)) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: leds=%b mode=%0d, expected leds=%b mode=%0d",
                             sb[i].nm, edge_n, leds, mode, sb[i].leds, sb[i].mode);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst     = 1'b1;
        buttons = 2'b00;
        exp_at(1, 2'b00, 1, 2'd0, "reset1");
        exp_at(2, 2'b00, 1, 2'd0, "reset2");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 3; t <= 27; t++) exp_at(t, 2'b00, 1, 2'd0, "idle");
        repeat (25) @(negedge clk);

        // single press, held long
        b0 = edge_n + 1;
        exp_at(b0 + 5, 2'b00, 1, 2'd0, "pre_on");
        exp_at(b0 + 6, 2'b00, 1, 2'd1, "mode_on");
        for (int t = b0 + 7; t <= b0 + 30; t++)
            exp_at(t, 2'b11, 1, 2'd1, "hold_on");
        press(2'b01, 10, 21);

        // 3-cycle glitch is ignored
        b0 = edge_n + 1;
        for (int t = b0; t <= b0 + 20; t++)
            exp_at(t, 2'b11, 1, 2'd1, "glitch");
        press(2'b01, 3, 18);

        // BLINK: lit 8, dark 8
        b0 = edge_n + 1;
        exp_at(b0 + 5, 2'b11, 1, 2'd1, "pre_blink");
        exp_at(b0 + 6, 2'b11, 1, 2'd2, "to_blink");
        for (int t = b0 + 7; t <= b0 + 38; t++)
            exp_at(t, (((t - b0 - 7) / 8) % 2) ? 2'b00 : 2'b11, 1, 2'd2, "blink");
        press(2'b01, 6, 34);

        // ALT: 01 for 8, 10 for 8
        b0 = edge_n + 1;
        exp_at(b0 + 5, 2'b00, 0, 2'd2, "pre_alt");
        exp_at(b0 + 6, 2'b00, 0, 2'd3, "to_alt");
        for (int t = b0 + 7; t <= b0 + 38; t++)
            exp_at(t, (((t - b0 - 7) / 8) % 2) ? 2'b10 : 2'b01, 1, 2'd3, "alt");
        press(2'b01, 6, 34);

        // wrap to OFF
        b0 = edge_n + 1;
        exp_at(b0 + 6, 2'b00, 0, 2'd0, "wrap");
        for (int t = b0 + 7; t <= b0 + 12; t++)
            exp_at(t, 2'b00, 1, 2'd0, "wrap_off");
        press(2'b01, 6, 10);

        // both buttons in ON: return wins over advance
        b0 = edge_n + 1;
        exp_at(b0 + 6, 2'b00, 0, 2'd1, "on2");
        press(2'b01, 6, 10);
        b0 = edge_n + 1;
        exp_at(b0 + 5, 2'b11, 1, 2'd1, "pre_both_on");
        exp_at(b0 + 6, 2'b11, 1, 2'd0, "both_on");
        exp_at(b0 + 7, 2'b00, 1, 2'd0, "both_on_leds");
        press(2'b11, 6, 10);

        // both buttons in ALT
        for (int k = 1; k <= 3; k++) begin
            b0 = edge_n + 1;
            exp_at(b0 + 6, 2'b00, 0, 2'(k), "step_alt");
            press(2'b01, 6, 10);
        end
        b0 = edge_n + 1;
        exp_at(b0 + 5, 2'b00, 0, 2'd3, "pre_both_alt");
        exp_at(b0 + 6, 2'b00, 0, 2'd0, "both_alt");
        exp_at(b0 + 7, 2'b00, 1, 2'd0, "both_alt_leds");
        press(2'b11, 6, 10);

        // reset while BLINK is lit
        b0 = edge_n + 1;
        exp_at(b0 + 6, 2'b00, 0, 2'd1, "on3");
        press(2'b01, 6, 10);
        b0 = edge_n + 1;
        exp_at(b0 + 6, 2'b00, 0, 2'd2, "blink2");
        exp_at(b0 + 7, 2'b11, 1, 2'd2, "blink2_lit");
        press(2'b01, 6, 2);
        exp_at(edge_n + 1, 2'b00, 1, 2'd0, "rst_blink");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = edge_n + 1; t <= edge_n + 12; t++)
            exp_at(t, 2'b00, 1, 2'd0, "post_rst");
        repeat (12) @(negedge clk);

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s edge %0d: never checked", sb[0].nm, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
